uart_rx_param: RTL and testbench

Parametrised, stand-alone UART receiver: the hard-logic successor to the PIO-program UART RX (wait/set/in/jmp loop).
- Adds beyond the PIO version:
  - configurable data width
  - parity checking
  - 1 or 2 stop bits
  - oversampled majority-vote sampling
  - false-start rejection
  - frame/parity error flags
  - receive FIFO with overrun detection
- Sits beside pio on the GPIO input side.
- Configured by registers from the same host interface that drives pio actions.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/uart_rx_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared constants, FSM encoding and FIFO entry layout for the
//               parametrised UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // FIFO entry layout: {parity_err, frame_err, data[DATA_BITS-1:0]}
    function automatic int frame_err_pos(input int data_bits);
        return data_bits;
    endfunction

    function automatic int parity_err_pos(input int data_bits);
        return data_bits + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO with occupancy level and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_rd;
    logic             w_wr;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (c_aw+1)'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a push onto a full FIFO is
    // accepted when paired with a pop.
    assign w_rd = i_rd & ~o_empty;
    assign w_wr = i_wr & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Oversampling UART receiver with parity, 1/2 stop bits, error
//               flags and receive FIFO. Macro UART_RX_BREAK_EN adds break
//               detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          dout_frame_err,
    output logic                          dout_parity_err,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic                          busy,
    output logic                          break_det
);

    localparam int c_os_w  = $clog2(OVERSAMPLE) + 1;
    localparam int c_bit_w = $clog2(DATA_BITS) + 1;
    localparam int c_ent_w = DATA_BITS + 2;
    localparam int c_fe    = frame_err_pos(DATA_BITS);
    localparam int c_pe    = parity_err_pos(DATA_BITS);
    localparam logic [c_os_w-1:0]  c_os_s0   = c_os_w'(OVERSAMPLE/2 - 1);
    localparam logic [c_os_w-1:0]  c_os_s1   = c_os_w'(OVERSAMPLE/2);
    localparam logic [c_os_w-1:0]  c_os_mid  = c_os_w'(OVERSAMPLE/2 + 1);
    localparam logic [c_os_w-1:0]  c_os_last = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_rx_d;
    logic                    w_rx;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [c_os_w-1:0]       r_os_cnt;
    logic [c_bit_w-1:0]      r_bit_cnt;
    logic                    r_s0;
    logic                    r_s1;
    logic [DATA_BITS-1:0]    r_shift;
    logic                    r_frame_err;
    logic                    r_par_err;
    logic                    r_push;
    logic [c_ent_w-1:0]      r_word;
    logic                    r_overrun;
    logic                    w_tick;
    logic                    w_mid;
    logic                    w_end;
    logic                    w_vote;
    logic                    w_par_en;
    logic                    w_last_stop;
    logic                    w_push_nxt;
    logic                    w_brk_hit;
    logic [c_ent_w-1:0]      w_rdata;
    logic                    w_full;
    logic                    w_empty;

    assign w_rx        = r_sync[SYNC_STAGES-1];
    assign w_tick      = (r_state != IDLE) && (r_div_cnt == div);
    assign w_mid       = w_tick && (r_os_cnt == c_os_mid);
    assign w_end       = w_tick && (r_os_cnt == c_os_last);
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_par_en    = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    assign w_last_stop = (r_bit_cnt == {{(c_bit_w-1){1'b0}}, stop_bits});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_d <= w_rx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rx_d && !w_rx) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_mid && w_vote) begin
                    w_state_nxt = IDLE;
                end else if (w_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_end && (r_bit_cnt == c_last_bit)) begin
                    w_state_nxt = w_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at mid-bit so a back-to-back start edge is not missed.
                if (w_mid && w_last_stop) begin
                    if (w_brk_hit) begin
                        w_state_nxt = BREAK;
                    end else begin
                        w_push_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            BREAK: begin
                if (w_tick && w_rx && (r_os_cnt == c_os_last)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = IDLE;
            w_push_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt   <= '0;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
            r_push      <= 1'b0;
            r_word      <= '0;
        end else begin
            r_push <= w_push_nxt;
            if (w_push_nxt) begin
                r_word <= {r_par_err, r_frame_err | ~w_vote, r_shift};
            end
            if (r_state == IDLE) begin
                r_div_cnt   <= '0;
                r_os_cnt    <= '0;
                r_bit_cnt   <= '0;
                r_frame_err <= 1'b0;
                r_par_err   <= 1'b0;
            end else begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                // In BREAK the tick counter instead counts consecutive high samples.
                if (w_state_nxt == BREAK && r_state != BREAK) begin
                    r_os_cnt <= '0;
                end else if (w_tick) begin
                    if (r_state == BREAK) begin
                        r_os_cnt <= w_rx ? r_os_cnt + 1'b1 : '0;
                    end else begin
                        r_os_cnt <= w_end ? '0 : r_os_cnt + 1'b1;
                    end
                end
                if (w_tick && r_os_cnt == c_os_s0) begin
                    r_s0 <= w_rx;
                end
                if (w_tick && r_os_cnt == c_os_s1) begin
                    r_s1 <= w_rx;
                end
                if (w_mid) begin
                    case (r_state)
                        DATA:    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        PARITY:  r_par_err <= ((^r_shift) ^ w_vote) != (parity_mode == PAR_ODD);
                        STOP:    r_frame_err <= r_frame_err | ~w_vote;
                        default: ;
                    endcase
                end
                if (w_end && (r_state == DATA || r_state == STOP)) begin
                    r_bit_cnt <= (r_state == DATA && r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_EN
    logic r_all_zero;
    logic r_break;

    assign w_brk_hit = r_all_zero & ~w_vote;
    assign break_det = r_break;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_all_zero <= 1'b1;
            r_break    <= 1'b0;
        end else begin
            r_break <= (r_state == STOP) && (w_state_nxt == BREAK);
            if (r_state == IDLE) begin
                r_all_zero <= 1'b1;
            end else if (w_mid && w_vote) begin
                r_all_zero <= 1'b0;
            end
        end
    end
`else
    assign w_brk_hit = 1'b0;
    assign break_det = 1'b0;
`endif

    uart_rx_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (r_push),
        .i_wdata (r_word),
        .i_rd    (dout_ready),
        .o_rdata (w_rdata),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (r_push && w_full && !dout_ready) begin
            r_overrun <= 1'b1;
        end else if (err_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun         = r_overrun;
    assign busy            = (r_state != IDLE);
    assign dout_valid      = ~w_empty;
    assign dout            = w_empty ? '0 : w_rdata[DATA_BITS-1:0];
    assign dout_frame_err  = ~w_empty & w_rdata[c_fe];
    assign dout_parity_err = ~w_empty & w_rdata[c_pe];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param against a frame-level
//               model (div=0, 16x oversampling, 8 data bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int BIT_CLK = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] div = 16'd0;
    logic [1:0]  parity_mode = 2'd0;
    logic        stop_bits = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  dout;
    logic        dout_frame_err;
    logic        dout_parity_err;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overrun;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        break_det;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];

    uart_rx_param #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .DIV_W       (16),
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .div             (div),
        .parity_mode     (parity_mode),
        .stop_bits       (stop_bits),
        .rx              (rx),
        .dout            (dout),
        .dout_frame_err  (dout_frame_err),
        .dout_parity_err (dout_parity_err),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .fifo_level      (fifo_level),
        .overrun         (overrun),
        .err_clr         (err_clr),
        .busy            (busy),
        .break_det       (break_det)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cycles(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic s0, input logic s1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (parity_mode == 2'd1 || parity_mode == 2'd2) send_bit(pb);
        send_bit(s0);
        if (stop_bits) send_bit(s1);
        rx = 1'b1;
    endtask

    task automatic pop_word(output logic [7:0] d, output logic fe, output logic pe);
        d  = dout;
        fe = dout_frame_err;
        pe = dout_parity_err;
        dout_ready = 1'b1;
        cycles(1);
        dout_ready = 1'b0;
    endtask

    // Parity bit a correct transmitter would send.
    function automatic logic good_par(input logic [7:0] d, input logic [1:0] pm);
        int ones;
        ones = $countones(d);
        return (pm == 2'd2) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    endfunction

    // Expected FIFO entry {parity_err, frame_err, data} for one transmitted frame.
    function automatic logic [9:0] model(input logic [7:0] d, input logic pb, input logic s0,
                                         input logic s1, input logic [1:0] pm, input logic sb);
        logic fe;
        logic pe;
        int   ones;
        fe   = (s0 == 1'b0) || (sb && s1 == 1'b0);
        ones = $countones(d) + int'(pb);
        if (pm == 2'd1)      pe = (ones % 2) != 0;
        else if (pm == 2'd2) pe = (ones % 2) != 1;
        else                 pe = 1'b0;
        return {pe, fe, d};
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        rx    = 1'b1;
        cycles(3);
        checks++; if (dout !== 8'h00)       begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (dout_frame_err !== 0) begin errors++; $display("FAIL reset_fe: got %b expected 0", dout_frame_err); end
        checks++; if (dout_parity_err !== 0) begin errors++; $display("FAIL reset_pe: got %b expected 0", dout_parity_err); end
        checks++; if (dout_valid !== 0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        checks++; if (fifo_level !== 4'd0)  begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (overrun !== 0)        begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 0)           begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (break_det !== 0)      begin errors++; $display("FAIL reset_break: got %b expected 0", break_det); end
        reset = 1'b1;
        cycles(4);
    endtask

    task automatic test_8n1;
        logic [7:0] d;
        logic fe, pe;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        fork
            send_frame(8'h55, 1'b0, 1'b1, 1'b1);
            begin : mon
                int n;
                n = 0;
                while (busy !== 1'b1 && n < 40) begin cycles(1); n++; end
                while (busy !== 1'b0 && n < 300) begin cycles(1); n++; end
                checks++;
                if (n >= 300) begin
                    errors++; $display("FAIL 8n1_timing: busy never fell within %0d cycles", n);
                end else begin
                    if (dout_valid !== 1'b0) begin errors++; $display("FAIL 8n1_valid_early: got %b expected 0", dout_valid); end
                    cycles(1);
                    checks++;
                    if (dout_valid !== 1'b1) begin errors++; $display("FAIL 8n1_valid_latency: got %b expected 1", dout_valid); end
                end
            end
        join
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL 8n1_level: got %0d expected 1", fifo_level); end
        pop_word(d, fe, pe);
        checks++; if ({pe, fe, d} !== {2'b00, 8'h55}) begin errors++; $display("FAIL 8n1_word: got %b_%b_%h expected 0_0_55", pe, fe, d); end
    endtask

    task automatic test_parity;
        logic [7:0] d;
        logic fe, pe;
        parity_mode = 2'd1;
        stop_bits   = 1'b0;
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b0, 1'b1, 1'b1);
        cycles(2);
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL par_level: got %0d expected 2", fifo_level); end
        pop_word(d, fe, pe);
        checks++; if ({pe, fe, d} !== {2'b10, 8'hA3}) begin errors++; $display("FAIL par_bad: got %b_%b_%h expected 1_0_a3", pe, fe, d); end
        pop_word(d, fe, pe);
        checks++; if ({pe, fe, d} !== {2'b00, 8'hA3}) begin errors++; $display("FAIL par_good: got %b_%b_%h expected 0_0_a3", pe, fe, d); end
        parity_mode = 2'd0;
    endtask

    task automatic test_false_start;
        int n;
        rx = 1'b0;
        cycles(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy: got %b expected 1", busy); end
        rx = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 9) begin cycles(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_idle: busy %b after %0d cycles expected 0", busy, n); end
        cycles(2 * BIT_CLK);
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL fs_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_frame_err;
        logic [7:0] d;
        logic fe, pe;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_frame(8'h10, 1'b0, 1'b1, 1'b1);
        cycles(2);
        pop_word(d, fe, pe);
        checks++; if ({pe, fe, d} !== {2'b01, 8'h0F}) begin errors++; $display("FAIL ferr_first: got %b_%b_%h expected 0_1_0f", pe, fe, d); end
        pop_word(d, fe, pe);
        checks++; if ({pe, fe, d} !== {2'b00, 8'h10}) begin errors++; $display("FAIL ferr_second: got %b_%b_%h expected 0_0_10", pe, fe, d); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic fe, pe;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b0, 1'b1, 1'b1);
        cycles(2);
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL b2b_level: got %0d expected 8", fifo_level); end
        checks++; if (overrun !== 1'b1)    begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dout_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_pop_valid: entry %0d not available", k);
            end else begin
                pop_word(d, fe, pe);
                if ({pe, fe, d} !== {2'b00, 8'(k)}) begin errors++; $display("FAIL b2b_pop: got %b_%b_%h expected 0_0_%h", pe, fe, d, 8'(k)); end
            end
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", fifo_level); end
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic fe, pe;
        logic [7:0] partial;
        partial     = 8'hA5;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        rx = partial[4];
        cycles(8);
        reset = 1'b0;
        rx    = 1'b1;
        cycles(1);
        reset = 1'b1;
        checks++; if ({dout_valid, fifo_level} !== 5'd0) begin errors++; $display("FAIL rmid_fifo: got valid %b level %0d expected 0 0", dout_valid, fifo_level); end
        checks++; if ({dout, dout_frame_err, dout_parity_err} !== 10'd0) begin errors++; $display("FAIL rmid_head: got %h %b %b expected 00 0 0", dout, dout_frame_err, dout_parity_err); end
        checks++; if ({busy, overrun, break_det} !== 3'b000) begin errors++; $display("FAIL rmid_status: got %b%b%b expected 000", busy, overrun, break_det); end
        cycles(2 * BIT_CLK);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        cycles(2);
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL rmid_level: got %0d expected 1", fifo_level); end
        pop_word(d, fe, pe);
        checks++; if ({pe, fe, d} !== {2'b00, 8'h3C}) begin errors++; $display("FAIL rmid_word: got %b_%b_%h expected 0_0_3c", pe, fe, d); end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic fe, pe, pb, s0, s1;
        logic [1:0] pm;
        logic sb;
        logic [9:0] exp_w;
        for (int batch = 0; batch < 3; batch++) begin
            for (int f = 0; f < 6; f++) begin
                pm = 2'($urandom_range(0, 3));
                sb = 1'($urandom_range(0, 1));
                parity_mode = pm;
                stop_bits   = sb;
                d  = 8'($urandom);
                pb = good_par(d, pm) ^ ($urandom_range(0, 3) == 0);
                s0 = 1'b1;
                s1 = 1'b1;
                if ($urandom_range(0, 4) == 0) begin
                    if (sb && $urandom_range(0, 1) == 1) s1 = 1'b0;
                    else s0 = 1'b0;
                    d[0] = 1'b1;
                end
                send_frame(d, pb, s0, s1);
                exp_q.push_back(model(d, pb, s0, s1, pm, sb));
                if (!s0 || (sb && !s1)) send_bit(1'b1);
            end
            cycles(2);
            checks++; if (fifo_level !== 4'(exp_q.size())) begin errors++; $display("FAIL rnd_level: got %0d expected %0d", fifo_level, exp_q.size()); end
            while (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (dout_valid !== 1'b1) begin
                    errors++; $display("FAIL rnd_valid: FIFO empty, expected %b", exp_w);
                end else begin
                    pop_word(d, fe, pe);
                    if ({pe, fe, d} !== exp_w) begin errors++; $display("FAIL rnd_word: got %b expected %b", {pe, fe, d}, exp_w); end
                end
            end
        end
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
    endtask

`ifdef UART_RX_BREAK_EN
    task automatic test_break;
        int pulses;
        pulses      = 0;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 15 * BIT_CLK; i++) begin
            cycles(1);
            if (break_det === 1'b1) pulses++;
        end
        rx = 1'b1;
        for (int i = 0; i < 3 * BIT_CLK; i++) begin
            cycles(1);
            if (break_det === 1'b1) pulses++;
        end
        checks++; if (pulses != 1)          begin errors++; $display("FAIL brk_pulses: got %0d expected 1", pulses); end
        checks++; if (fifo_level !== 4'd0)  begin errors++; $display("FAIL brk_level: got %0d expected 0", fifo_level); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL brk_busy: got %b expected 0", busy); end
    endtask
`endif

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_false_start;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef UART_RX_BREAK_EN
        test_break;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
